// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  // r0 is hardwired to zero, so a load targeting it never creates a hazard
  localparam int REG_ZERO = 0;

  // Pipeline steering bundle produced each cycle
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_flush;
    logic pipe_hold;
  } ctl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use compare for one issue slot: the ID/EX load writes a register
// that the IF/ID instruction reads, which forwarding cannot cover in time.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  lu_hit
);

  assign lu_hit = ex_mem_read &
                  (ex_rd != REG_ADDR_W'(REG_ZERO)) &
                  ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: load-use bubble, redirect
// flush, and whole-pipe freeze on slow data memory. Also tracks stall
// cycles and flags memory accesses that wait too long.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 15,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_redirect,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  input  logic                  perf_clr,
  output logic                  pc_we,
  output logic                  if_id_we,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_flush,
  output logic                  pipe_hold,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  timeout_err
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_e            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              lu_hit, lu_eff, hold;
  ctl_t              ctl;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .lu_hit      (lu_hit)
  );

  // Next-state and steering decode: memory freeze > redirect > load-use > normal
  always_comb begin
    ctl          = '0;
    ctl.pc_we    = 1'b1;
    ctl.if_id_we = 1'b1;
    state_nxt    = RUN;
    wait_nxt     = '0;
    // The bubble already issued for this load lets MEM/WB forwarding take over
    lu_eff       = lu_hit & (state != LU_STALL);
    // Once waiting, only dmem_ready releases the freeze
    hold         = (state == MEM_WAIT) ? ~dmem_ready : (dmem_req & ~dmem_ready);
    if (hold) begin
      ctl.pc_we     = 1'b0;
      ctl.if_id_we  = 1'b0;
      ctl.pipe_hold = 1'b1;
      state_nxt     = MEM_WAIT;
      if (state != MEM_WAIT)      wait_nxt = WAIT_W'(1);
      else if (wait_cnt != WAIT_MAX) wait_nxt = wait_cnt + 1'b1;
      else                        wait_nxt = wait_cnt;
    end else if (mem_redirect) begin
      ctl.if_id_flush  = 1'b1;
      ctl.id_ex_bubble = 1'b1;
      ctl.ex_mem_flush = 1'b1;
    end else if (lu_eff) begin
      ctl.pc_we        = 1'b0;
      ctl.if_id_we     = 1'b0;
      ctl.id_ex_bubble = 1'b1;
      state_nxt        = LU_STALL;
    end
  end

  // Force a safe, NOP-filling pipe while reset is held
  always_comb begin
    if (arst) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
      pipe_hold    = 1'b0;
    end else begin
      pc_we        = ctl.pc_we;
      if_id_we     = ctl.if_id_we;
      if_id_flush  = ctl.if_id_flush;
      id_ex_bubble = ctl.id_ex_bubble;
      ex_mem_flush = ctl.ex_mem_flush;
      pipe_hold    = ctl.pipe_hold;
    end
  end

  // FSM state and memory wait counter
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Perf counter and sticky timeout; clear wins over count and set
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else if (perf_clr) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!ctl.pc_we && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (hold && (wait_nxt == WAIT_MAX))
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: table of single-cycle decode
// vectors plus hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  localparam int RW = 5;
  localparam int MW = 4;
  localparam int CW = 4;

  // {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold}
  localparam logic [5:0] O_NORM  = 6'b110000;
  localparam logic [5:0] O_LU    = 6'b000100;
  localparam logic [5:0] O_REDIR = 6'b111110;
  localparam logic [5:0] O_HOLD  = 6'b000001;
  localparam logic [5:0] O_RST   = 6'b001110;

  logic          clk = 1'b0;
  logic          arst;
  logic [RW-1:0] id_rs, id_rt, ex_rd;
  logic          id_uses_rt, ex_mem_read, mem_redirect, dmem_req, dmem_ready, perf_clr;
  logic          pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold;
  logic [CW-1:0] stall_cnt;
  logic          timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .arst(arst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_redirect(mem_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .perf_clr(perf_clr),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_flush(ex_mem_flush), .pipe_hold(pipe_hold),
    .stall_cnt(stall_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] rs, rt;
    logic          uses_rt, mem_read;
    logic [RW-1:0] rd;
    logic          redir, req, rdy;
    logic [5:0]    exp;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [5:0] outs();
    return {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic urt,
                       input logic mrd, input logic [RW-1:0] rd, input logic redir,
                       input logic req, input logic rdy);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mrd; ex_rd = rd;
    mem_redirect = redir; dmem_req = req; dmem_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  // lw r3 in ID/EX, add r4,r3,r5 in IF/ID
  task automatic lu_pair(input logic req, input logic rdy, input logic redir);
    drive(5'd3, 5'd5, 1'b1, 1'b1, 5'd3, redir, req, rdy);
  endtask

  task automatic clear_perf();
    @(negedge clk); idle(1'b1); perf_clr = 1'b1;
    @(negedge clk); perf_clr = 1'b0;
  endtask

  initial begin
    //          rs  rt  urt mrd rd  redir req rdy exp
    tbl[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, O_NORM};
    tbl[1]  = '{5'd3, 5'd5, 0, 1, 5'd3, 0, 0, 0, O_LU};    // rs match
    tbl[2]  = '{5'd5, 5'd3, 1, 1, 5'd3, 0, 0, 0, O_LU};    // rt match, rt used
    tbl[3]  = '{5'd5, 5'd3, 0, 1, 5'd3, 0, 0, 0, O_NORM};  // rt match, rt unused
    tbl[4]  = '{5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, O_NORM};  // r0 never hazards
    tbl[5]  = '{5'd3, 5'd3, 1, 0, 5'd3, 0, 0, 0, O_NORM};  // not a load
    tbl[6]  = '{5'd1, 5'd2, 1, 0, 5'd7, 1, 0, 0, O_REDIR};
    tbl[7]  = '{5'd3, 5'd5, 1, 1, 5'd3, 1, 0, 0, O_REDIR}; // redirect beats lu
    tbl[8]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, O_HOLD};
    tbl[9]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, O_NORM};  // single-cycle access
    tbl[10] = '{5'd3, 5'd5, 1, 1, 5'd3, 1, 1, 0, O_HOLD};  // mem wait beats all
    tbl[11] = '{5'd31,5'd9, 1, 1, 5'd31,0, 0, 1, O_LU};    // top register

    arst = 1'b1; perf_clr = 1'b0; idle(1'b0);
    #2;
    chk("rst_outs", 32'(outs()), 32'(O_RST));
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    @(negedge clk); arst = 1'b0;

    // Decode table, each vector followed by a cycle that returns to RUN
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].rs, tbl[i].rt, tbl[i].uses_rt, tbl[i].mem_read, tbl[i].rd,
            tbl[i].redir, tbl[i].req, tbl[i].rdy);
      #1 chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      @(negedge clk); idle(1'b1);
      #1 chk($sformatf("vec%0d_after", i), 32'(outs()), 32'(O_NORM));
    end

    // Load-use: exactly one bubble, then masked
    clear_perf();
    lu_pair(1'b0, 1'b0, 1'b0);
    #1 chk("lu_bubble", 32'(outs()), 32'(O_LU));
    @(negedge clk); lu_pair(1'b0, 1'b0, 1'b0);
    #1 chk("lu_masked", 32'(outs()), 32'(O_NORM));
    @(negedge clk); idle(1'b1);
    #1 chk("lu_stall_cnt", 32'(stall_cnt), 1);
    // Memory wait honoured while in LU_STALL
    lu_pair(1'b0, 1'b0, 1'b0);
    @(negedge clk); lu_pair(1'b1, 1'b0, 1'b0);
    #1 chk("lu_then_hold", 32'(outs()), 32'(O_HOLD));
    @(negedge clk); idle(1'b1);
    #1 chk("lu_hold_release", 32'(outs()), 32'(O_NORM));

    // Three-cycle memory wait, release on the fourth
    clear_perf();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      #1 chk($sformatf("wait%0d", k), 32'(outs()), 32'(O_HOLD));
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    #1 chk("wait_release", 32'(outs()), 32'(O_NORM));
    @(negedge clk); idle(1'b1);
    #1 chk("wait_stall_cnt", 32'(stall_cnt), 3);
    // Redirect held through a wait acts on the release cycle
    drive(0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    #1 chk("redir_held", 32'(outs()), 32'(O_HOLD));
    @(negedge clk); drive(0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b1);
    #1 chk("redir_release", 32'(outs()), 32'(O_REDIR));
    // Load-use held through a wait bubbles on release, then masked
    @(negedge clk); lu_pair(1'b1, 1'b0, 1'b0);
    #1 chk("lu_held", 32'(outs()), 32'(O_HOLD));
    @(negedge clk); lu_pair(1'b1, 1'b1, 1'b0);
    #1 chk("lu_release", 32'(outs()), 32'(O_LU));
    @(negedge clk); lu_pair(1'b0, 1'b1, 1'b0);
    #1 chk("lu_release_masked", 32'(outs()), 32'(O_NORM));

    // Timeout after the 4th wait cycle, sticky, cleared by perf_clr
    clear_perf();
    drive(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1 chk($sformatf("timeout_c%0d", k), 32'(timeout_err), (k >= 4) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    @(negedge clk); idle(1'b0);
    #1 chk("timeout_sticky", 32'(timeout_err), 1);
    chk("timeout_stall_cnt", 32'(stall_cnt), 6);
    perf_clr = 1'b1;
    @(negedge clk); perf_clr = 1'b0;
    #1 chk("timeout_clr", 32'(timeout_err), 0);
    chk("stall_clr", 32'(stall_cnt), 0);

    // stall_cnt saturation, and perf_clr winning over increment and set
    drive(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    #1 chk("stall_sat", 32'(stall_cnt), 15);
    perf_clr = 1'b1;
    @(negedge clk); perf_clr = 1'b0;
    #1 chk("clr_prio_cnt", 32'(stall_cnt), 0);
    chk("clr_prio_to", 32'(timeout_err), 0);
    @(negedge clk);
    #1 chk("after_clr_cnt", 32'(stall_cnt), 1);
    chk("after_clr_to", 32'(timeout_err), 1);
    drive(0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    @(negedge clk); idle(1'b0);

    // Asynchronous reset in the middle of a memory wait
    drive(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #2 arst = 1'b1;
    #1 chk("arst_outs", 32'(outs()), 32'(O_RST));
    chk("arst_stall_cnt", 32'(stall_cnt), 0);
    chk("arst_timeout", 32'(timeout_err), 0);
    @(negedge clk); arst = 1'b0; idle(1'b0);
    #1 chk("arst_release_pc_we", 32'(outs()), 32'(O_NORM));
    @(negedge clk);
    #1 chk("arst_release_cnt", 32'(stall_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
